// File: rtl/histeq_pkg.sv
// Shared types and constants for the histogram equalizer stages.
package histeq_pkg;

    localparam int          NUM_BINS = 256;
    localparam int          CDF_W    = 32;
    localparam logic [15:0] HIST_TAG = 16'hAAAA;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } cdf_state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] count;
    } bin_entry_t;

endpackage

// File: rtl/hist_bin_decode.sv
// Combinational decode of one 128-bit m2 histogram entry into {valid, count}.
module hist_bin_decode
    import histeq_pkg::*;
(
    input  logic [127:0] entry_raw,
    output bin_entry_t   entry
);

    // Only the low word carries tag and count; the rest of the entry is ignored.
    logic unused_upper;
    assign unused_upper = ^entry_raw[127:32];

    assign entry.valid = (entry_raw[31:16] == HIST_TAG);
    assign entry.count = entry.valid ? entry_raw[15:0] : 16'h0000;

endmodule

// File: rtl/histogram_cdf_pipeline.sv
// Scans the 256-bin m2 histogram, writes the running CDF to m3, reports total and cdf_min.
// Optional macro CDF_CLEAR_ON_READ_EN: zero each m2 bin in the cycle its CDF is written.
module histogram_cdf_pipeline
    import histeq_pkg::*;
(
    input  logic          clock,
    input  logic          rst_n,
    input  logic          start,
    input  logic          base_sel,
    input  logic [127:0]  m2ReadVal,
    output logic [15:0]   m2ReadAddr,
    output logic          m2WE,
    output logic [15:0]   m2WriteAddr,
    output logic [127:0]  m2WriteVal,
    output logic          m3WE,
    output logic [15:0]   m3WriteAddr,
    output logic [127:0]  m3WriteVal,
    output logic [31:0]   cdf_min,
    output logic [31:0]   pixel_total,
    output logic          done
);

    cdf_state_t       state, state_next;
    logic [7:0]       bin_cnt;
    logic             issue_v, data_v;
    logic [7:0]       data_bin;
    logic [CDF_W-1:0] acc, cdf_next;
    logic             found;
    logic             scan_start, issuing, drain_last;
    bin_entry_t       entry;

    hist_bin_decode u_decode (
        .entry_raw (m2ReadVal),
        .entry     (entry)
    );

    assign cdf_next    = acc + {{(CDF_W-16){1'b0}}, entry.count};
    assign drain_last  = m3WE && (m3WriteAddr[7:0] == 8'(NUM_BINS-1));
    assign pixel_total = acc;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (!start) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_next = SCAN;
                SCAN:    if (bin_cnt == 8'(NUM_BINS-1)) state_next = DRAIN;
                DRAIN:   if (drain_last) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        scan_start = (state == IDLE) && start;
        issuing    = (state == SCAN) && start;
        done       = (state == DONE) && start;
    end

    // Stages: ISSUE (m2ReadAddr) -> DATA (RAM latency) -> ACCUM+WRITE (m3 registers).
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt     <= '0;
            issue_v     <= 1'b0;
            data_v      <= 1'b0;
            data_bin    <= '0;
            acc         <= '0;
            found       <= 1'b0;
            cdf_min     <= '0;
            m2ReadAddr  <= '0;
            m3WE        <= 1'b0;
            m3WriteAddr <= '0;
            m3WriteVal  <= '0;
        end else if (!start) begin
            issue_v <= 1'b0;
            data_v  <= 1'b0;
            m3WE    <= 1'b0;
        end else begin
            if (scan_start) begin
                bin_cnt <= '0;
                acc     <= '0;
                cdf_min <= '0;
                found   <= 1'b0;
            end
            if (issuing) begin
                m2ReadAddr <= {7'b0, base_sel, bin_cnt};
                bin_cnt    <= bin_cnt + 8'd1;
            end
            // NOTE: non-blocking so every stage samples the previous stage's old value.
            issue_v  <= issuing;
            data_v   <= issue_v;
            data_bin <= m2ReadAddr[7:0];
            m3WE     <= data_v;
            if (data_v) begin
                acc         <= cdf_next;
                m3WriteAddr <= {8'b0, data_bin};
                m3WriteVal  <= {{(128-CDF_W){1'b0}}, cdf_next};
                if (!found && entry.valid && entry.count != 16'h0000) begin
                    cdf_min <= cdf_next;
                    found   <= 1'b1;
                end
            end
        end
    end

`ifdef CDF_CLEAR_ON_READ_EN
    // Clear goes to the bank the bin was actually read from.
    logic data_bank;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            data_bank   <= 1'b0;
            m2WE        <= 1'b0;
            m2WriteAddr <= '0;
        end else begin
            data_bank <= m2ReadAddr[8];
            m2WE      <= data_v && start;
            if (data_v) m2WriteAddr <= {7'b0, data_bank, data_bin};
        end
    end

    assign m2WriteVal = '0;
`else
    assign m2WE        = 1'b0;
    assign m2WriteAddr = '0;
    assign m2WriteVal  = '0;
`endif

endmodule

// File: tb/tb_histogram_cdf_pipeline.sv
// Self-checking bench for histogram_cdf_pipeline against a behavioural CDF model.
module tb_histogram_cdf_pipeline;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         start;
    logic         base_sel;
    logic [127:0] m2ReadVal;
    logic [15:0]  m2ReadAddr;
    logic         m2WE;
    logic [15:0]  m2WriteAddr;
    logic [127:0] m2WriteVal;
    logic         m3WE;
    logic [15:0]  m3WriteAddr;
    logic [127:0] m3WriteVal;
    logic [31:0]  cdf_min;
    logic [31:0]  pixel_total;
    logic         done;

    histogram_cdf_pipeline dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .base_sel    (base_sel),
        .m2ReadVal   (m2ReadVal),
        .m2ReadAddr  (m2ReadAddr),
        .m2WE        (m2WE),
        .m2WriteAddr (m2WriteAddr),
        .m2WriteVal  (m2WriteVal),
        .m3WE        (m3WE),
        .m3WriteAddr (m3WriteAddr),
        .m3WriteVal  (m3WriteVal),
        .cdf_min     (cdf_min),
        .pixel_total (pixel_total),
        .done        (done)
    );

    always #5 clock = ~clock;

`ifdef CDF_CLEAR_ON_READ_EN
    localparam int EXP_M2_WRITES = 256;
`else
    localparam int EXP_M2_WRITES = 0;
`endif

    int assertions = 0;
    int failures   = 0;

    logic [127:0] mem2 [512];
    logic [31:0]  m3   [256];
    logic [31:0]  exp_cdf [256];
    logic [31:0]  exp_total, exp_min;
    int           done_cycle, wr_count, wr_err, m2_count, m2_err;

    // Single-cycle RAM models: read data one cycle after the address, writes on the edge.
    always @(posedge clock) begin
        m2ReadVal <= mem2[m2ReadAddr[8:0]];
        if (m2WE) mem2[m2WriteAddr[8:0]] = '0;
        if (m3WE) m3[m3WriteAddr[7:0]] = m3WriteVal[31:0];
    end

    function automatic void build_model(input logic bank);
        logic [31:0]  run;
        logic [127:0] e;
        logic [15:0]  cnt;
        run     = 0;
        exp_min = 0;
        for (int k = 0; k < 256; k++) begin
            e   = mem2[{bank, 8'(k)}];
            cnt = (e[31:16] == 16'hAAAA) ? e[15:0] : 16'h0;
            run = run + {16'h0, cnt};
            exp_cdf[k] = run;
            if (exp_min == 0 && cnt != 0) exp_min = run;
        end
        exp_total = run;
    endfunction

    // mode: 0 all {AAAA,1}; 1 all zero; 2 only bin 200 tagged; 3 all {AAAA,FFFF}; 4 random
    task automatic fill(input logic bank, input int mode);
        logic [8:0]  idx;
        logic [31:0] r;
        for (int i = 0; i < 512; i++) mem2[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int k = 0; k < 256; k++) begin
            idx = {bank, 8'(k)};
            r   = $urandom();
            case (mode)
                0: mem2[idx] = {$urandom(), $urandom(), $urandom(), 16'hAAAA, 16'd1};
                1: mem2[idx] = '0;
                2: mem2[idx] = (k == 200) ? {96'h0, 16'hAAAA, 16'd64} : {96'h0, 16'h1234, r[15:0]};
                3: mem2[idx] = {$urandom(), $urandom(), $urandom(), 16'hAAAA, 16'hFFFF};
                default: mem2[idx] = {96'h0, (r[1:0] != 2'b00) ? 16'hAAAA : r[31:16],
                                      r[2] ? 16'h0 : 16'($urandom())};
            endcase
        end
    endtask

    task automatic run_scan(input logic bank);
        for (int k = 0; k < 256; k++) m3[k] = 32'hDEAD_BEEF;
        build_model(bank);
        done_cycle = -1;
        wr_count = 0; wr_err = 0; m2_count = 0; m2_err = 0;
        @(negedge clock);
        base_sel = bank;
        start    = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (m3WE) begin
                wr_count++;
                if (m3WriteAddr !== 16'(c-3) || m3WriteVal[127:32] !== 96'h0) wr_err++;
            end
            if (m2WE) begin
                m2_count++;
                if (m2WriteAddr !== {7'h0, bank, 8'(c-3)} || m2WriteVal !== 128'h0) m2_err++;
            end
            if (done) begin
                done_cycle = c;
                break;
            end
        end
    endtask

    task automatic stop_run();
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_sel = 1'b0;
        #23;
        assertions++;
        if ({m3WE, m2WE, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes: got m3WE/m2WE/done=%b expected 000", {m3WE, m2WE, done});
        end
        assertions++;
        if ({m2ReadAddr, m3WriteAddr, m2WriteAddr} !== 48'h0) begin
            failures++;
            $display("FAIL reset_addrs: got %h expected 0", {m2ReadAddr, m3WriteAddr, m2WriteAddr});
        end
        assertions++;
        if ({m3WriteVal, m2WriteVal} !== 256'h0) begin
            failures++;
            $display("FAIL reset_data: got nonzero write data, expected 0");
        end
        assertions++;
        if ({cdf_min, pixel_total} !== 64'h0) begin
            failures++;
            $display("FAIL reset_results: got cdf_min=%h total=%h expected 0", cdf_min, pixel_total);
        end
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        int          mode;
        logic        bank;
        logic        has_const;
        logic [31:0] total;
        logic [31:0] min;
    } frame_t;

    task automatic test_frames();
        frame_t tab [6];
        int     bad, first;
        logic [31:0] want_total, want_min;
        tab[0] = '{0, 1'b0, 1'b1, 32'd256,       32'd1};
        tab[1] = '{1, 1'b1, 1'b1, 32'd0,         32'd0};
        tab[2] = '{2, 1'b0, 1'b1, 32'd64,        32'd64};
        tab[3] = '{3, 1'b1, 1'b1, 32'h00FF_FF00, 32'h0000_FFFF};
        tab[4] = '{4, 1'b0, 1'b0, 32'd0,         32'd0};
        tab[5] = '{4, 1'b1, 1'b0, 32'd0,         32'd0};
        for (int t = 0; t < 6; t++) begin
            fill(tab[t].bank, tab[t].mode);
            run_scan(tab[t].bank);
            want_total = tab[t].has_const ? tab[t].total : exp_total;
            want_min   = tab[t].has_const ? tab[t].min   : exp_min;
            assertions++;
            if (done_cycle != 259) begin
                failures++;
                $display("FAIL frame%0d_done_cycle: got %0d expected 259", t, done_cycle);
            end
            assertions++;
            if (wr_count != 256 || wr_err != 0) begin
                failures++;
                $display("FAIL frame%0d_m3_writes: got %0d writes, %0d misplaced; expected 256, 0", t, wr_count, wr_err);
            end
            assertions++;
            if (m2_count != EXP_M2_WRITES || m2_err != 0) begin
                failures++;
                $display("FAIL frame%0d_m2_writes: got %0d writes, %0d bad; expected %0d, 0", t, m2_count, m2_err, EXP_M2_WRITES);
            end
            bad = 0; first = 0;
            for (int k = 0; k < 256; k++)
                if (m3[k] !== exp_cdf[k]) begin
                    if (bad == 0) first = k;
                    bad++;
                end
            assertions++;
            if (bad != 0) begin
                failures++;
                $display("FAIL frame%0d_m3_cdf: %0d bad entries, m3[%0d]=%h expected %h", t, bad, first, m3[first], exp_cdf[first]);
            end
            assertions++;
            if (pixel_total !== want_total || cdf_min !== want_min || m3WE !== 1'b0) begin
                failures++;
                $display("FAIL frame%0d_results: got total=%h min=%h m3WE=%b expected %h %h 0", t, pixel_total, cdf_min, m3WE, want_total, want_min);
            end
            stop_run();
            assertions++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL frame%0d_done_drop: got done=%b expected 0", t, done);
            end
        end
    endtask

    task automatic test_abort_restart();
        int done_seen, bad;
        fill(1'b0, 0);
        @(negedge clock);
        base_sel = 1'b0;
        start    = 1'b1;
        for (int c = 0; c <= 101; c++) begin
            @(posedge clock);
            @(negedge clock);
        end
        assertions++;
        if (m2ReadAddr !== 16'd100) begin
            failures++;
            $display("FAIL abort_issue_point: got m2ReadAddr=%h expected 0064", m2ReadAddr);
        end
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        assertions++;
        if ({m3WE, m2WE, done} !== 3'b000) begin
            failures++;
            $display("FAIL abort_strobes: got m3WE/m2WE/done=%b expected 000", {m3WE, m2WE, done});
        end
        done_seen = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (done || m3WE) done_seen++;
        end
        assertions++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL abort_quiet: got %0d cycles with done/m3WE, expected 0", done_seen);
        end
        fill(1'b0, 0);
        run_scan(1'b0);
        bad = 0;
        for (int k = 0; k < 256; k++) if (m3[k] !== 32'(k + 1)) bad++;
        assertions++;
        if (done_cycle != 259 || bad != 0 || pixel_total !== 32'd256 || cdf_min !== 32'd1) begin
            failures++;
            $display("FAIL restart_frame: got done_cycle=%0d bad=%0d total=%h min=%h expected 259 0 100 1", done_cycle, bad, pixel_total, cdf_min);
        end
        stop_run();
    endtask

    task automatic test_reset_mid_scan();
        fill(1'b1, 4);
        @(negedge clock);
        base_sel = 1'b1;
        start    = 1'b1;
        for (int c = 0; c < 50; c++) @(negedge clock);
        #2 rst_n = 1'b0;
        #1;
        assertions++;
        if ({m3WE, m2WE, done} !== 3'b000 || {m2ReadAddr, m3WriteAddr} !== 32'h0) begin
            failures++;
            $display("FAIL midscan_reset_ctrl: got strobes=%b addrs=%h expected 000 0", {m3WE, m2WE, done}, {m2ReadAddr, m3WriteAddr});
        end
        assertions++;
        if ({m3WriteVal[31:0], cdf_min, pixel_total} !== 96'h0) begin
            failures++;
            $display("FAIL midscan_reset_results: got val=%h min=%h total=%h expected 0", m3WriteVal[31:0], cdf_min, pixel_total);
        end
        start = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
    endtask

`ifdef CDF_CLEAR_ON_READ_EN
    task automatic test_clear_on_read();
        int left;
        fill(1'b1, 0);
        run_scan(1'b1);
        stop_run();
        left = 0;
        for (int k = 0; k < 256; k++) if (mem2[{1'b1, 8'(k)}] !== 128'h0) left++;
        assertions++;
        if (left != 0 || m2_count != 256) begin
            failures++;
            $display("FAIL clear_bank: got %0d uncleared bins, %0d m2 writes; expected 0, 256", left, m2_count);
        end
        run_scan(1'b1);
        assertions++;
        if (done_cycle != 259 || pixel_total !== 32'h0 || cdf_min !== 32'h0) begin
            failures++;
            $display("FAIL clear_second_run: got done_cycle=%0d total=%h min=%h expected 259 0 0", done_cycle, pixel_total, cdf_min);
        end
        stop_run();
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_abort_restart();
        test_reset_mid_scan();
`ifdef CDF_CLEAR_ON_READ_EN
        test_clear_on_read();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
